udp_tx_framer: RTL and testbench



---
 rtl/udp_tx_framer_pkg.sv | 22 ++
 rtl/udp_tx_framer.sv | 184 ++++++++++++++++++
 tb/tb_udp_tx_framer.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_tx_framer_pkg.sv
// -----------------------------------------------------------------------------
// udp_tx_framer_pkg
//
// Purpose : Shared helper for the UDP TX framer. Holds the MSB-first byte
//           selector used for both payload words and the trailer word.
// Contents: msb_byte(word, idx) -> byte idx of word, idx 0 = bits [31:24].
// -----------------------------------------------------------------------------
package udp_tx_framer_pkg;

    function automatic logic [7:0] msb_byte(input logic [31:0] word,
                                            input logic [1:0]  idx);
        logic [7:0] result;
        case (idx)
            2'd0:    result = word[31:24];
            2'd1:    result = word[23:16];
            2'd2:    result = word[15:8];
            default: result = word[7:0];
        endcase
        return result;
    endfunction

endpackage

// File: rtl/udp_tx_framer.sv
// -----------------------------------------------------------------------------
// udp_tx_framer
//
// Purpose : Packs 32-bit sample words into byte-wide AXI-stream UDP payload
//           frames. Each frame carries up to WORDS_PER_FRAME words (MSB byte
//           first) followed by a 4-byte trailer {seq[15:0], word_cnt[15:0]}.
//           tlast marks the final trailer byte. flush closes a partially
//           filled frame early; a flush with no frame open is ignored.
//
// Parameters:
//   WORDS_PER_FRAME  maximum payload words per frame (1..65535)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_word_tdata      input sample word
//   s_word_tvalid     input word valid
//   s_word_tready     input word accepted (combinational on flush only)
//   flush             close the open frame (level or pulse)
//   m_axis_tdata      payload/trailer byte
//   m_axis_tvalid     output byte valid
//   m_axis_tready     downstream ready
//   m_axis_tlast      last trailer byte
//   m_axis_tuser      tied 0
//   frame_seq         sequence number of the next frame to be sent
//   busy              a frame is open
// -----------------------------------------------------------------------------
module udp_tx_framer
    import udp_tx_framer_pkg::*;
#(
    parameter int unsigned WORDS_PER_FRAME = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_word_tdata,
    input  logic        s_word_tvalid,
    output logic        s_word_tready,
    input  logic        flush,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [15:0] frame_seq,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_TRAILER = 2'd3;

    localparam int unsigned TRAILER_BYTES = 4;
    localparam logic [1:0]  LAST_BYTE     = 2'(TRAILER_BYTES - 1);
    localparam logic [15:0] MAX_WORDS     = 16'(WORDS_PER_FRAME);

    logic [1:0]  state_q,      state_d;
    logic [31:0] word_q,       word_d;
    logic [1:0]  byte_idx_q,   byte_idx_d;
    logic [15:0] word_cnt_q,   word_cnt_d;
    logic [15:0] seq_q,        seq_d;
    logic        flush_pend_q, flush_pend_d;

    logic word_hs;
    logic out_hs;

    // Output decode uses registers only; flush -> s_word_tready is the single
    // combinational input-to-output path.
    assign s_word_tready = ((state_q == ST_IDLE) || (state_q == ST_WAIT))
                           && !flush_pend_q && !flush;
    assign m_axis_tvalid = (state_q == ST_PAYLOAD) || (state_q == ST_TRAILER);
    assign m_axis_tlast  = (state_q == ST_TRAILER) && (byte_idx_q == LAST_BYTE);
    assign m_axis_tuser  = 1'b0;
    assign frame_seq     = seq_q;
    assign busy          = (state_q != ST_IDLE);

    always_comb begin
        case (state_q)
            ST_PAYLOAD: m_axis_tdata = msb_byte(word_q, byte_idx_q);
            ST_TRAILER: m_axis_tdata = msb_byte({seq_q, word_cnt_q}, byte_idx_q);
            default:    m_axis_tdata = 8'h00;
        endcase
    end

    assign word_hs = s_word_tvalid && s_word_tready;
    assign out_hs  = m_axis_tvalid && m_axis_tready;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so paths
        // that do not assign it cannot infer a latch.
        state_d      = state_q;
        word_d       = word_q;
        byte_idx_d   = byte_idx_q;
        word_cnt_d   = word_cnt_q;
        seq_d        = seq_q;
        flush_pend_d = flush_pend_q;

        case (state_q)
            ST_IDLE: begin
                // A flush here is dropped on purpose: empty frames are never sent.
                if (word_hs) begin
                    word_d     = s_word_tdata;
                    word_cnt_d = 16'd1;
                    byte_idx_d = 2'd0;
                    state_d    = ST_PAYLOAD;
                end
            end

            ST_PAYLOAD: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (out_hs) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == LAST_BYTE) begin
                        if ((word_cnt_q == MAX_WORDS) || flush_pend_q) begin
                            state_d      = ST_TRAILER;
                            byte_idx_d   = 2'd0;
                            // Entering the trailer consumes any pending flush,
                            // including one raised on this very cycle.
                            flush_pend_d = 1'b0;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end

            ST_WAIT: begin
                // Flush has priority over a simultaneous word; s_word_tready is
                // already low in that case so the word stays with the source.
                if (flush || flush_pend_q) begin
                    state_d      = ST_TRAILER;
                    byte_idx_d   = 2'd0;
                    flush_pend_d = 1'b0;
                end else if (word_hs) begin
                    word_d     = s_word_tdata;
                    word_cnt_d = word_cnt_q + 16'd1;
                    byte_idx_d = 2'd0;
                    state_d    = ST_PAYLOAD;
                end
            end

            default: begin // ST_TRAILER
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (out_hs) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == LAST_BYTE) begin
                        seq_d        = seq_q + 16'd1;
                        word_cnt_d   = 16'd0;
                        state_d      = ST_IDLE;
                        // No frame is open any more, so a flush seen during
                        // the trailer has nothing left to close.
                        flush_pend_d = 1'b0;
                    end
                end
            end
        endcase
    end

    // NOTE: reset is synchronous, so it sits inside the clocked branch and is
    // not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            word_q       <= 32'd0;
            byte_idx_q   <= 2'd0;
            word_cnt_q   <= 16'd0;
            seq_q        <= 16'd0;
            flush_pend_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed from the previous state, independent of order.
            state_q      <= state_d;
            word_q       <= word_d;
            byte_idx_q   <= byte_idx_d;
            word_cnt_q   <= word_cnt_d;
            seq_q        <= seq_d;
            flush_pend_q <= flush_pend_d;
        end
    end

endmodule

// File: tb/tb_udp_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_udp_tx_framer
//
// Purpose : Self-checking bench for udp_tx_framer (WORDS_PER_FRAME = 2).
//           A frame-level model turns observed word handshakes and flushes
//           into the expected byte stream (payload bytes, then trailer
//           {seq, count}); a monitor compares every output handshake against
//           it and checks stall stability, busy and frame_seq each cycle.
//           Directed sequences pin the model with literal byte expectations.
// -----------------------------------------------------------------------------
module tb_udp_tx_framer;

    localparam int WPF = 2;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } obyte_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_word_tdata;
    logic        s_word_tvalid;
    logic        s_word_tready;
    logic        flush;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [15:0] frame_seq;
    logic        busy;

    always #4 clk = ~clk;

    udp_tx_framer #(.WORDS_PER_FRAME(WPF)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_word_tdata  (s_word_tdata),
        .s_word_tvalid (s_word_tvalid),
        .s_word_tready (s_word_tready),
        .flush         (flush),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .frame_seq     (frame_seq),
        .busy          (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural frame model ----------------
    obyte_t      exp_q[$];   // bytes the DUT still owes
    obyte_t      log_q[$];   // every byte actually handed downstream
    logic [7:0]  want[$];    // literal expectations for directed tests
    bit          m_open;
    bit          m_closing;
    logic [15:0] m_cnt;
    logic [15:0] close_seq;
    logic [15:0] done_seq;
    bit          stall_q;
    logic [7:0]  stall_data;
    logic        stall_last;
    bit          bp_en = 1'b0;

    task automatic push_byte(input logic [7:0] d, input logic l);
        exp_q.push_back(obyte_t'{d, l});
    endtask

    task automatic model_close();
        push_byte(close_seq[15:8], 1'b0);
        push_byte(close_seq[7:0],  1'b0);
        push_byte(m_cnt[15:8],     1'b0);
        push_byte(m_cnt[7:0],      1'b1);
        close_seq = close_seq + 16'd1;
        m_closing = 1'b1;
    endtask

    always @(negedge clk) begin
        obyte_t e;
        if (rst) begin
            exp_q.delete();
            m_open    = 1'b0;
            m_closing = 1'b0;
            m_cnt     = 16'd0;
            close_seq = 16'd0;
            done_seq  = 16'd0;
            stall_q   = 1'b0;
        end else begin
            check("busy", busy, m_open);
            check("frame_seq", frame_seq, done_seq);
            check("tuser", m_axis_tuser, 0);
            if (!m_open) check("idle_tvalid", m_axis_tvalid, 0);
            if (stall_q) begin
                check("stall_tvalid", m_axis_tvalid, 1);
                check("stall_tdata", m_axis_tdata, stall_data);
                check("stall_tlast", m_axis_tlast, stall_last);
            end

            if (m_axis_tvalid && m_axis_tready) begin
                log_q.push_back(obyte_t'{m_axis_tdata, m_axis_tlast});
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h expected=none at %0t", m_axis_tdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", m_axis_tdata, e.data);
                    check("tlast", m_axis_tlast, e.last);
                    if (e.last) begin
                        m_open    = 1'b0;
                        m_closing = 1'b0;
                        done_seq  = done_seq + 16'd1;
                    end
                end
            end
            stall_q    = m_axis_tvalid && !m_axis_tready;
            stall_data = m_axis_tdata;
            stall_last = m_axis_tlast;

            if (s_word_tvalid && s_word_tready) begin
                if (m_open && m_closing) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_while_closing actual=accepted expected=blocked at %0t", $time);
                end
                if (!m_open) begin
                    m_open    = 1'b1;
                    m_closing = 1'b0;
                    m_cnt     = 16'd0;
                end
                m_cnt = m_cnt + 16'd1;
                push_byte(s_word_tdata[31:24], 1'b0);
                push_byte(s_word_tdata[23:16], 1'b0);
                push_byte(s_word_tdata[15:8],  1'b0);
                push_byte(s_word_tdata[7:0],   1'b0);
                if (m_cnt == 16'(WPF)) model_close();
            end else if (flush && m_open && !m_closing) begin
                model_close();
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        bit done = 1'b0;
        s_word_tdata  = w;
        s_word_tvalid = 1'b1;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            done = s_word_tready;
            tick();
        end
        s_word_tvalid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Frame open but no byte on offer: the framer is waiting for a word.
    task automatic wait_in_wait();
        bit done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            if (busy && !m_axis_tvalid) done = 1'b1;
            else tick();
        end
        if (!done) check("wait_state_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            if (!busy && exp_q.size() == 0) done = 1'b1;
            else tick();
        end
        if (!done) check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic expect_bytes(input int base, input string tag);
        check({tag, "_len"}, log_q.size() - base, want.size());
        for (int i = 0; i < want.size(); i++) begin
            if (base + i < log_q.size()) check(tag, log_q[base + i].data, want[i]);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        int          base;
        logic [15:0] target;

        rst           = 1'b1;
        s_word_tdata  = 32'd0;
        s_word_tvalid = 1'b0;
        flush         = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 8'h00);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_seq", frame_seq, 16'h0000);
        check("rst_tready", s_word_tready, 1);
        rst = 1'b0;
        tick();

        // Full frame of two words, closed by the word count
        base = log_q.size();
        send_word(32'hDEADBEEF);
        send_word(32'h01020304);
        drain();
        want = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04,
                 8'h00, 8'h00, 8'h00, 8'h02};
        expect_bytes(base, "full_frame");
        for (int i = 0; i < 12; i++) begin
            if (base + i < log_q.size()) check("full_frame_tlast", log_q[base + i].last, (i == 11));
        end
        check("full_frame_seq", frame_seq, 16'h0001);

        // One word then flush while waiting for the next word
        base = log_q.size();
        send_word(32'hCAFEF00D);
        wait_in_wait();
        pulse_flush();
        drain();
        want = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h00, 8'h01, 8'h00, 8'h01};
        expect_bytes(base, "flush_frame");

        // Flush in IDLE produces nothing
        base = log_q.size();
        pulse_flush();
        repeat (10) tick();
        check("idle_flush_bytes", log_q.size() - base, 0);
        check("idle_flush_busy", busy, 0);

        // Flush together with a word in WAIT: the word goes to the next frame
        base = log_q.size();
        send_word(32'h11111111);
        wait_in_wait();
        s_word_tdata  = 32'h22222222;
        s_word_tvalid = 1'b1;
        flush         = 1'b1;
        @(negedge clk);
        check("flush_blocks_tready", s_word_tready, 0);
        tick();
        flush = 1'b0;
        send_word(32'h22222222);
        wait_in_wait();
        pulse_flush();
        drain();
        want = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h00, 8'h02, 8'h00, 8'h01,
                 8'h22, 8'h22, 8'h22, 8'h22, 8'h00, 8'h03, 8'h00, 8'h01};
        expect_bytes(base, "flush_vs_word");

        // Reset while byte 2 of the payload is on offer
        base = log_q.size();
        send_word(32'hA5C3_96E1);
        for (int n = 0; n < 50 && (log_q.size() - base) < 2; n++) tick();
        rst = 1'b1;
        tick();
        check("midrst_tvalid", m_axis_tvalid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_seq", frame_seq, 16'h0000);
        rst = 1'b0;
        tick();
        base = log_q.size();
        send_word(32'h5A5A5A5A);
        wait_in_wait();
        pulse_flush();
        drain();
        want = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h01};
        expect_bytes(base, "after_rst");

        // Sequence wrap: preload 0xFFFF
        force dut.seq_q = 16'hFFFF;
        close_seq = 16'hFFFF;
        done_seq  = 16'hFFFF;
        tick();
        release dut.seq_q;
        check("preload_seq", frame_seq, 16'hFFFF);
        base = log_q.size();
        send_word(32'h01234567);
        send_word(32'h89ABCDEF);
        drain();
        send_word(32'h0F0F0F0F);
        wait_in_wait();
        pulse_flush();
        drain();
        want = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF,
                 8'hFF, 8'hFF, 8'h00, 8'h02,
                 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h01};
        expect_bytes(base, "seq_wrap");
        check("wrap_frame_seq", frame_seq, 16'h0001);

        // Random words, flushes and downstream backpressure over 20 frames
        bp_en  = 1'b1;
        target = done_seq + 16'd20;
        for (int it = 0; it < 3000 && done_seq != target; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 7) send_word($urandom);
            else if (r < 9) pulse_flush();
            else repeat ($urandom_range(1, 5)) tick();
        end
        check("random_frames_done", done_seq, target);
        pulse_flush();
        drain();
        bp_en = 1'b0;
        repeat (5) tick();
        check("final_exp_empty", exp_q.size(), 0);
        check("final_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
